dcache_lite: RTL

- Data-cache responder at the far end of the EX/MEM dcache request bus.
- Consumes the packed request bus driven by the load/store address unit and returns the packed ready/rvalid/rdata bus.
- Direct-mapped, write-through, no-write-allocate cache with an uncached bypass path.
- Memory side is a simple read-burst / single-write handshake toward the bus bridge.

---
 rtl/dcache_lite_pkg.sv | 46 ++++
 rtl/dcache_lite_array.sv | 70 +++++++
 rtl/dcache_lite.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_lite_pkg.sv
// Shared definitions for dcache_lite: request/response bus widths and field
// offsets, FSM state encoding and memory read-type constants.
// Optional feature macro: DCACHE_CACOP_EN (adds the cache-op state).
`ifndef DCACHE_LITE_DEFS
`define DCACHE_LITE_DEFS
`define EXM_DCACHE_WD 106
`define EXM_DCACHE_RD 34
`endif

package dcache_lite_pkg;

   // Request bus: {valid, op, addr, uncached, awstrb, wdata, cacop_en, cacop_code, cacop_addr}
   localparam int WD_VALID         = 105;
   localparam int WD_OP            = 104;
   localparam int WD_ADDR_LSB      = 72;
   localparam int WD_UNCACHED      = 71;
   localparam int WD_STRB_LSB      = 67;
   localparam int WD_WDATA_LSB     = 35;
   localparam int WD_COP_EN        = 34;
   localparam int WD_COP_CODE_LSB  = 32;
   localparam int WD_COP_ADDR_LSB  = 0;

   // Response bus: {ready, rvalid, rdata}
   localparam int RD_READY         = 33;
   localparam int RD_RVALID        = 32;

   localparam logic RD_TYPE_WORD   = 1'b0;
   localparam logic RD_TYPE_LINE   = 1'b1;

   localparam logic [1:0] COP_INDEX_INV = 2'd0;
   localparam logic [1:0] COP_HIT_INV   = 2'd1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_MISS   = 3'd2,
      S_REFILL = 3'd3,
      S_RESP   = 3'd4,
      S_WRITE  = 3'd5
`ifdef DCACHE_CACOP_EN
      ,
      S_CACOP  = 3'd6
`endif
   } state_t;

endpackage

// File: rtl/dcache_lite_array.sv
// Tag, valid and data storage for dcache_lite. Combinational read of one
// word plus tag/valid of the addressed line; byte-strobed word write;
// line valid set (with tag) and clear. Valid bits clear on resetn.
module dcache_lite_array #(
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 4
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [INDEX_W-1:0]              rd_index,
   input  logic [OFFSET_W-3:0]             rd_word,
   output logic [31-INDEX_W-OFFSET_W:0]    rd_tag,
   output logic                            rd_valid,
   output logic [31:0]                     rd_data,
   input  logic                            word_we,
   input  logic [INDEX_W-1:0]              word_index,
   input  logic [OFFSET_W-3:0]             word_sel,
   input  logic [3:0]                      word_strb,
   input  logic [31:0]                     word_data,
   input  logic                            line_set,
   input  logic [INDEX_W-1:0]              set_index,
   input  logic [31-INDEX_W-OFFSET_W:0]    set_tag,
   input  logic                            line_clr,
   input  logic [INDEX_W-1:0]              clr_index
);

   localparam int LINES  = 1 << INDEX_W;
   localparam int WORD_W = OFFSET_W - 2;
   localparam int DEPTH  = LINES << WORD_W;

   logic [31-INDEX_W-OFFSET_W:0] tag_mem [LINES];
   logic [LINES-1:0]             valid_reg;
   logic [INDEX_W+WORD_W-1:0]    rd_addr;
   logic [INDEX_W+WORD_W-1:0]    wr_addr;

   assign rd_addr  = {rd_index, rd_word};
   assign wr_addr  = {word_index, word_sel};
   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid_reg[rd_index];

   // Line valid bits: cleared on reset or invalidate, set on refill completion
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_reg <= '0;
      end else begin
         if (line_clr) valid_reg[clr_index] <= 1'b0;
         if (line_set) valid_reg[set_index] <= 1'b1;
      end
   end

   // Tag written together with the valid bit at refill completion
   always_ff @(posedge clk) begin
      if (line_set) tag_mem[set_index] <= set_tag;
   end

   // One byte lane per generate slice so strobes map to independent writes
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] byte_mem [DEPTH];

         // Byte-lane write under its strobe bit
         always_ff @(posedge clk) begin
            if (word_we && word_strb[gi]) byte_mem[wr_addr] <= word_data[gi*8 +: 8];
         end

         assign rd_data[gi*8 +: 8] = byte_mem[rd_addr];
      end
   endgenerate

endmodule

// File: rtl/dcache_lite.sv
// dcache_lite: direct-mapped, write-through, no-write-allocate data cache
// responder with uncached bypass. Memory side: read (word or line burst)
// and single-word write handshakes.
// Optional feature macro: DCACHE_CACOP_EN (index / hit invalidate ops).
module dcache_lite
   import dcache_lite_pkg::*;
#(
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 4
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [`EXM_DCACHE_WD-1:0]   dcache_wdata_bus,
   output logic [`EXM_DCACHE_RD-1:0]   dcache_rdata_bus,
   output logic                        rd_req,
   output logic                        rd_type,
   output logic [31:0]                 rd_addr,
   input  logic                        rd_ready,
   input  logic                        ret_valid,
   input  logic [31:0]                 ret_data,
   output logic                        wr_req,
   output logic [31:0]                 wr_addr,
   output logic [3:0]                  wr_strb,
   output logic [31:0]                 wr_data,
   input  logic                        wr_ready
);

   localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
   localparam int WORD_W = OFFSET_W - 2;
   localparam logic [WORD_W-1:0] LAST_BEAT = {WORD_W{1'b1}};

   // Request bus fields
   logic        req_valid, req_op, req_unc;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   assign req_valid = dcache_wdata_bus[WD_VALID];
   assign req_op    = dcache_wdata_bus[WD_OP];
   assign req_addr  = dcache_wdata_bus[WD_ADDR_LSB +: 32];
   assign req_unc   = dcache_wdata_bus[WD_UNCACHED];
   assign req_strb  = dcache_wdata_bus[WD_STRB_LSB +: 4];
   assign req_wdata = dcache_wdata_bus[WD_WDATA_LSB +: 32];

   state_t              state_reg, state_next;
   logic                op_reg, unc_reg;
   logic [31:0]         addr_reg, wdata_reg, result_reg;
   logic [3:0]          strb_reg;
   logic [WORD_W-1:0]   beat_reg;

   logic                resp_ready, resp_rvalid;
   logic [31:0]         resp_rdata;

   logic [INDEX_W-1:0]  addr_index, look_index;
   logic [TAG_W-1:0]    addr_tag, look_tag;
   logic [WORD_W-1:0]   addr_word;
   assign addr_index = addr_reg[OFFSET_W +: INDEX_W];
   assign addr_tag   = addr_reg[31 -: TAG_W];
   assign addr_word  = addr_reg[2 +: WORD_W];

   // Array interface
   logic [TAG_W-1:0]    arr_tag;
   logic                arr_valid, arr_we, arr_set, arr_clr, hit;
   logic [31:0]         arr_data, arr_wdata;
   logic [WORD_W-1:0]   arr_sel;
   logic [3:0]          arr_strb;

`ifdef DCACHE_CACOP_EN
   logic                req_cop_en;
   logic [1:0]          req_cop_code, cop_code_reg;
   logic [31:OFFSET_W]  req_cop_line, cop_line_reg;
   assign req_cop_en   = dcache_wdata_bus[WD_COP_EN];
   assign req_cop_code = dcache_wdata_bus[WD_COP_CODE_LSB +: 2];
   assign req_cop_line = dcache_wdata_bus[WD_COP_ADDR_LSB + OFFSET_W +: 32 - OFFSET_W];
   assign look_index   = (state_reg == S_CACOP) ? cop_line_reg[OFFSET_W +: INDEX_W] : addr_index;
   assign look_tag     = (state_reg == S_CACOP) ? cop_line_reg[31 -: TAG_W] : addr_tag;
`else
   logic unused_cacop;
   assign unused_cacop = ^dcache_wdata_bus[WD_COP_EN:0];
   assign look_index   = addr_index;
   assign look_tag     = addr_tag;
`endif

   assign hit = arr_valid && (arr_tag == look_tag);

   dcache_lite_array #(
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W)
   ) u_array (
      .clk        (clk),
      .resetn     (resetn),
      .rd_index   (look_index),
      .rd_word    (addr_word),
      .rd_tag     (arr_tag),
      .rd_valid   (arr_valid),
      .rd_data    (arr_data),
      .word_we    (arr_we),
      .word_index (addr_index),
      .word_sel   (arr_sel),
      .word_strb  (arr_strb),
      .word_data  (arr_wdata),
      .line_set   (arr_set),
      .set_index  (addr_index),
      .set_tag    (addr_tag),
      .line_clr   (arr_clr),
      .clr_index  (look_index)
   );

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_reg <= S_IDLE;
      else         state_reg <= state_next;
   end

   // Next state, handshake outputs and array write controls
   always_comb begin
      state_next  = state_reg;
      resp_ready  = 1'b0;
      resp_rvalid = 1'b0;
      resp_rdata  = '0;
      rd_req      = 1'b0;
      wr_req      = 1'b0;
      arr_we      = 1'b0;
      arr_sel     = addr_word;
      arr_strb    = strb_reg;
      arr_wdata   = wdata_reg;
      arr_set     = 1'b0;
      arr_clr     = 1'b0;
      case (state_reg)
         S_IDLE: begin
`ifdef DCACHE_CACOP_EN
            if (req_cop_en) begin
               state_next = S_CACOP;
            end else begin
               resp_ready = 1'b1;
               if (req_valid) state_next = S_LOOKUP;
            end
`else
            resp_ready = 1'b1;
            if (req_valid) state_next = S_LOOKUP;
`endif
         end
         S_LOOKUP: begin
            if (op_reg) begin
               // Write-through: merge into a resident line, never allocate
               arr_we     = !unc_reg && hit;
               state_next = S_WRITE;
            end else if (!unc_reg && hit) begin
               resp_rvalid = 1'b1;
               resp_rdata  = arr_data;
               state_next  = S_IDLE;
            end else begin
               state_next = S_MISS;
            end
         end
         S_MISS: begin
            rd_req = 1'b1;
            if (rd_ready) state_next = S_REFILL;
         end
         S_REFILL: begin
            if (ret_valid) begin
               if (unc_reg) begin
                  state_next = S_RESP;
               end else begin
                  arr_we    = 1'b1;
                  arr_sel   = beat_reg;
                  arr_strb  = 4'hF;
                  arr_wdata = ret_data;
                  if (beat_reg == LAST_BEAT) begin
                     arr_set    = 1'b1;
                     state_next = S_RESP;
                  end
               end
            end
         end
         S_RESP: begin
            resp_rvalid = 1'b1;
            resp_rdata  = result_reg;
            state_next  = S_IDLE;
         end
         S_WRITE: begin
            wr_req = 1'b1;
            if (wr_ready) state_next = S_IDLE;
         end
`ifdef DCACHE_CACOP_EN
         S_CACOP: begin
            arr_clr    = (cop_code_reg == COP_INDEX_INV) ||
                         ((cop_code_reg == COP_HIT_INV) && hit);
            state_next = S_IDLE;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Request capture, refill beat counter and read result
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_reg     <= 1'b0;
         unc_reg    <= 1'b0;
         addr_reg   <= '0;
         strb_reg   <= '0;
         wdata_reg  <= '0;
         beat_reg   <= '0;
         result_reg <= '0;
`ifdef DCACHE_CACOP_EN
         cop_code_reg <= '0;
         cop_line_reg <= '0;
`endif
      end else begin
         if (resp_ready && req_valid) begin
            op_reg    <= req_op;
            unc_reg   <= req_unc;
            addr_reg  <= req_addr;
            strb_reg  <= req_strb;
            wdata_reg <= req_wdata;
         end
`ifdef DCACHE_CACOP_EN
         if (state_reg == S_IDLE && req_cop_en) begin
            cop_code_reg <= req_cop_code;
            cop_line_reg <= req_cop_line;
         end
`endif
         if (state_reg == S_MISS && rd_ready) beat_reg <= '0;
         if (state_reg == S_REFILL && ret_valid) begin
            beat_reg <= beat_reg + 1'b1;
            if (unc_reg || beat_reg == addr_word) result_reg <= ret_data;
         end
      end
   end

   assign dcache_rdata_bus = {resp_ready, resp_rvalid, resp_rdata};
   assign rd_type = unc_reg ? RD_TYPE_WORD : RD_TYPE_LINE;
   assign rd_addr = unc_reg ? addr_reg : {addr_reg[31:OFFSET_W], {OFFSET_W{1'b0}}};
   assign wr_addr = addr_reg;
   assign wr_strb = strb_reg;
   assign wr_data = wdata_reg;

endmodule
